// File: rtl/frame_tx_scheduler_if.sv
// Handshake bundle between the frame scheduler, the RAM read port, the UART Tx
// and the frame-indicator line. The scheduler sits on the slave side.
interface frame_tx_scheduler_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  i_Enable;
  logic                  i_VS;
  logic                  i_Tx_Done;
  logic                  o_Read_Enable;
  logic [ADDR_WIDTH-1:0] o_Read_Address;
  logic                  o_Tx_Start;
  logic                  o_Frame_Indicator;
  logic                  o_Busy;
  logic [7:0]            o_Frame_Count;

  modport master (
    output i_Enable, i_VS, i_Tx_Done,
    input  o_Read_Enable, o_Read_Address, o_Tx_Start,
           o_Frame_Indicator, o_Busy, o_Frame_Count
  );

  modport slave (
    input  i_Enable, i_VS, i_Tx_Done,
    output o_Read_Enable, o_Read_Address, o_Tx_Start,
           o_Frame_Indicator, o_Busy, o_Frame_Count
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// Frame transmit scheduler: once camera VS has been stable for a settle period,
// walks the frame-buffer RAM from address 0 to the last byte, handing each byte
// to the UART Tx and leaving a one-bit-time gap after every byte so the MCU can
// find byte boundaries. A hold period after the frame separates frames.
module frame_tx_scheduler #(
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_WIDTH      = 15,
  parameter int SETTLE_CYCLES   = 62500000,
  parameter int GAP_CYCLES      = 1085,
  parameter int HOLD_CYCLES     = 62500000,
  parameter int CNT_WIDTH       = 26
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  frame_tx_scheduler_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0]  SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LAST    = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = ADDR_WIDTH'(BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_READ,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic                  vs_p0, vs_p1;
  logic [CNT_WIDTH-1:0]  timer, timer_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [7:0]            frame_cnt, frame_cnt_nxt;
  logic                  read_en_q, tx_start_q, frame_ind_q, busy_q;

  // VS synchronizer: stage 0 may go metastable, stage 1 is the usable VS.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      vs_p0 <= bus.i_VS;
      vs_p1 <= vs_p0;
    end
  end

  // State, shared timer, read address and completed-frame counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      addr      <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      addr      <= addr_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Next-state logic; the timer is zeroed on every transition so each state
  // counts from 0. Losing VS or enable during SETTLE wins over settle expiry.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    addr_nxt      = addr;
    frame_cnt_nxt = frame_cnt;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        addr_nxt  = '0;
        if (bus.i_Enable && vs_p1) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!vs_p1 || !bus.i_Enable) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == SETTLE_LAST) begin
          state_nxt = S_READ;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_WIDTH'(1);
        end
      end
      S_READ: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (bus.i_Tx_Done) begin
          state_nxt = S_GAP;
          timer_nxt = '0;
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          timer_nxt = '0;
          if (addr == ADDR_LAST) begin
            addr_nxt      = '0;
            frame_cnt_nxt = frame_cnt + 8'd1;
            state_nxt     = S_DONE;
          end else begin
            addr_nxt  = addr + ADDR_WIDTH'(1);
            state_nxt = S_READ;
          end
        end else begin
          timer_nxt = timer + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (timer == HOLD_LAST) begin
          timer_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
        addr_nxt  = '0;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they line up with the
  // state register and stay glitch-free.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      read_en_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      frame_ind_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      read_en_q   <= (state_nxt == S_READ);
      tx_start_q  <= (state_nxt == S_LOAD);
      frame_ind_q <= (state_nxt == S_IDLE);
      busy_q      <= (state_nxt != S_IDLE);
    end
  end

  assign bus.o_Read_Enable     = read_en_q;
  assign bus.o_Tx_Start        = tx_start_q;
  assign bus.o_Frame_Indicator = frame_ind_q;
  assign bus.o_Busy            = busy_q;
  assign bus.o_Read_Address    = addr;
  assign bus.o_Frame_Count     = frame_cnt;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Bench for frame_tx_scheduler with small parameters. A Tx model answers each
// start after a chosen latency; an inline scoreboard tracks the expected byte
// order and frame count, and frame timing is predicted from the byte-period
// arithmetic (READ + LOAD + Tx time + gap).
module tb_frame_tx_scheduler;

  localparam int BPF    = 4;
  localparam int AW     = 4;
  localparam int SETTLE = 5;
  localparam int GAP    = 3;
  localparam int HOLD   = 6;
  localparam int CW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  frame_tx_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  frame_tx_scheduler #(
    .BYTES_PER_FRAME(BPF),
    .ADDR_WIDTH     (AW),
    .SETTLE_CYCLES  (SETTLE),
    .GAP_CYCLES     (GAP),
    .HOLD_CYCLES    (HOLD),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tx model: done pulse a fixed number of cycles after each start, an
  // optional stray second pulse landing in the gap, or a manual pulse.
  int cur_lat  = 2;
  bit tx_auto  = 1'b1;
  bit stray_en = 1'b0;
  int man_req  = 0;
  int man_ack  = 0;
  int tx_cnt   = 0;
  bit tx_stray = 1'b0;

  initial begin
    bus.i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.i_Tx_Done = 1'b0;
      if (rst) begin
        tx_cnt   = 0;
        tx_stray = 1'b0;
      end else begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            bus.i_Tx_Done = 1'b1;
            tx_stray      = stray_en && ($urandom_range(0, 1) == 1);
          end
        end else if (tx_stray) begin
          bus.i_Tx_Done = 1'b1;
          tx_stray      = 1'b0;
        end else if (man_ack != man_req) begin
          bus.i_Tx_Done = 1'b1;
          man_ack       = man_req;
        end
        if (tx_auto && bus.o_Tx_Start) tx_cnt = cur_lat;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]  frames_done = '0;
  logic [7:0]  exp_fc = '0;
  bit          prev_re = 1'b0;
  int          re_count = 0;
  int          ts_count = 0;
  bit          noise_on = 1'b0;

  typedef struct {
    int n;
    bit en;
    bit start;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: advance to the falling edge, then update the scoreboard.
  task automatic tick();
    @(negedge clk);
    if (noise_on) begin
      bus.i_VS     = 1'($urandom_range(0, 1));
      bus.i_Enable = 1'($urandom_range(0, 1));
    end
    if (rst) begin
      exp_addr    = '0;
      frames_done = '0;
      prev_re     = 1'b0;
    end else begin
      chk("fi_eq_not_busy", bus.o_Frame_Indicator, !bus.o_Busy);
      chk("re_ts_exclusive", bus.o_Read_Enable & bus.o_Tx_Start, 0);
      chk("ts_follows_re", bus.o_Tx_Start, prev_re);
      if (bus.o_Read_Enable) begin
        chk("read_addr", bus.o_Read_Address, exp_addr);
        chk("count_at_read", bus.o_Frame_Count, frames_done);
        if (exp_addr == AW'(BPF - 1)) begin
          exp_addr = '0;
          frames_done++;
        end else begin
          exp_addr++;
        end
        re_count++;
      end
      if (bus.o_Tx_Start) ts_count++;
      prev_re = bus.o_Read_Enable;
    end
  endtask

  task automatic wait_re(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.o_Read_Enable) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400 && bus.o_Busy; i++) tick();
    chk(nm, bus.o_Busy, 0);
  endtask

  // Full frame from IDLE. mode 0: VS/enable held to the last byte;
  // mode 1: both dropped after the second byte; mode 2: random VS/enable
  // noise plus stray Tx done pulses once the frame is under way.
  task automatic run_frame(input int lat, input int mode);
    int c0, r0, p, ts0;
    bit f;
    cur_lat  = lat;
    stray_en = (mode == 2);
    p        = 2 + lat + GAP;
    ts0      = ts_count;
    c0       = cyc;
    bus.i_VS     = 1'b1;
    bus.i_Enable = 1'b1;
    wait_re(20, f);
    chk("frame_started", f, 1);
    chk("settle_latency", cyc - c0, 3 + SETTLE);
    r0 = cyc;
    if (mode == 2) noise_on = 1'b1;
    for (int b = 1; b < BPF; b++) begin
      if (b == 2 && mode == 1) begin
        bus.i_VS     = 1'b0;
        bus.i_Enable = 1'b0;
      end
      if (b == BPF - 1) begin
        noise_on     = 1'b0;
        bus.i_VS     = 1'b0;
        bus.i_Enable = 1'b0;
      end
      wait_re(p + 2, f);
      chk("byte_seen", f, 1);
      chk("byte_period", cyc - r0, b * p);
    end
    while (cyc < r0 + BPF * p) tick();
    exp_fc++;
    chk("frame_count_done", bus.o_Frame_Count, exp_fc);
    chk("busy_in_done", bus.o_Busy, 1);
    while (cyc < r0 + BPF * p + HOLD - 1) tick();
    chk("busy_end_hold", bus.o_Busy, 1);
    tick();
    chk("idle_after_hold", bus.o_Frame_Indicator, 1);
    chk("busy_after_hold", bus.o_Busy, 0);
    chk("tx_starts_per_frame", ts_count - ts0, BPF);
    stray_en = 1'b0;
  endtask

  initial begin
    int c0, r0, x, re0, ts0;
    bit f;

    tbl[0] = '{n: 2, en: 1'b1, start: 1'b0};
    tbl[1] = '{n: 3, en: 1'b1, start: 1'b0};
    tbl[2] = '{n: 5, en: 1'b1, start: 1'b0};
    tbl[3] = '{n: 6, en: 1'b1, start: 1'b1};
    tbl[4] = '{n: 9, en: 1'b0, start: 1'b0};

    bus.i_VS     = 1'b0;
    bus.i_Enable = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_fi", bus.o_Frame_Indicator, 1);
    chk("reset_busy", bus.o_Busy, 0);
    chk("reset_re", bus.o_Read_Enable, 0);
    chk("reset_ts", bus.o_Tx_Start, 0);
    chk("reset_fc", bus.o_Frame_Count, 0);
    chk("reset_addr", bus.o_Read_Address, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Basic frame with 10-cycle Tx
    run_frame(10, 0);

    // VS pulse length / enable table
    cur_lat = 2;
    for (int i = 0; i < 5; i++) begin
      c0 = cyc;
      bus.i_VS     = 1'b1;
      bus.i_Enable = tbl[i].en;
      f = 1'b0;
      while (cyc < c0 + 20 && !f) begin
        if (cyc >= c0 + tbl[i].n) bus.i_VS = 1'b0;
        tick();
        if (bus.o_Read_Enable) f = 1'b1;
      end
      bus.i_VS     = 1'b0;
      bus.i_Enable = 1'b0;
      chk("table_start", f, tbl[i].start);
      if (f) begin
        chk("table_latency", cyc - c0, 3 + SETTLE);
        wait_idle("table_frame_end");
        exp_fc++;
      end else begin
        repeat (3) tick();
        chk("table_idle", bus.o_Busy, 0);
      end
      chk("table_fc", bus.o_Frame_Count, exp_fc);
    end

    // VS and enable dropped mid-frame
    run_frame(4, 1);

    // Tx done withheld for 100 cycles
    tx_auto = 1'b0;
    bus.i_VS     = 1'b1;
    bus.i_Enable = 1'b1;
    wait_re(20, f);
    chk("stall_frame_started", f, 1);
    bus.i_VS     = 1'b0;
    bus.i_Enable = 1'b0;
    re0 = re_count;
    tick();
    chk("stall_ts_in_load", bus.o_Tx_Start, 1);
    ts0 = ts_count;
    repeat (100) tick();
    chk("stall_no_read", re_count - re0, 0);
    chk("stall_no_start", ts_count - ts0, 0);
    chk("stall_addr", bus.o_Read_Address, 0);
    chk("stall_busy", bus.o_Busy, 1);
    tx_auto = 1'b1;
    cur_lat = 2;
    x = cyc;
    man_req++;
    wait_re(10, f);
    chk("stall_next_read", f, 1);
    chk("stall_gap_len", cyc - x, 1 + GAP);
    chk("stall_next_addr", bus.o_Read_Address, 1);
    wait_idle("stall_frame_end");
    exp_fc++;
    chk("stall_fc", bus.o_Frame_Count, exp_fc);

    // Asynchronous reset in the gap after byte 2
    cur_lat = 2;
    bus.i_VS     = 1'b1;
    bus.i_Enable = 1'b1;
    wait_re(20, f);
    chk("rst_frame_started", f, 1);
    r0 = cyc;
    bus.i_VS     = 1'b0;
    bus.i_Enable = 1'b0;
    while (cyc < r0 + 2 * (2 + 2 + GAP)) tick();
    chk("rst_pre_addr", bus.o_Read_Address, 2);
    while (cyc < r0 + 2 * (2 + 2 + GAP) + 5) tick();
    chk("rst_pre_busy", bus.o_Busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_re", bus.o_Read_Enable, 0);
    chk("rst_async_ts", bus.o_Tx_Start, 0);
    chk("rst_async_fi", bus.o_Frame_Indicator, 1);
    chk("rst_async_busy", bus.o_Busy, 0);
    chk("rst_async_fc", bus.o_Frame_Count, 0);
    chk("rst_async_addr", bus.o_Read_Address, 0);
    tick();
    tick();
    rst = 1'b0;
    exp_fc = '0;
    tick();
    run_frame(3, 0);

    // Randomized frames until the frame counter wraps
    for (int k = 0; k < 255; k++) begin
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end
    chk("frame_count_wrap", bus.o_Frame_Count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
